// File: rtl/mux_operand_sequencer.sv
// Operand register bank and select sequencer feeding a WIDTH-bit 4:1 operand mux.
// Optional build macro MUX_SEQ_SHUFFLE_EN rotates each pass's select order by an LFSR offset.
module mux_operand_sequencer #(
  parameter int WIDTH  = 16,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic [PASS_W-1:0] passes,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  W0,
  output logic [WIDTH-1:0]  W1,
  output logic [WIDTH-1:0]  W2,
  output logic [WIDTH-1:0]  W3,
  output logic [1:0]        S,
  output logic              sel_valid,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]        state_r, state_s;
  logic [1:0]        s_r, s_s;
  logic              sel_valid_r, sel_valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              wr_err_r;
  logic [1:0]        step_r, step_s;
  logic [PASS_W-1:0] pass_r, pass_s;
  logic [PASS_W-1:0] passes_r, passes_s;
  logic [WIDTH-1:0]  w_r [4];
  logic              hs_s;
  logic              wr_ok_s;
  logic              wr_bad_s;
  logic [1:0]        start_off_s;

`ifdef MUX_SEQ_SHUFFLE_EN
  logic [3:0] lfsr_r;

  // Free-running x^4+x^3+1 LFSR; its low bits pick the starting select of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 4'b1001;
    end else begin
      lfsr_r <= {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[2]};
    end
  end

  assign start_off_s = lfsr_r[1:0];
`else
  assign start_off_s = 2'd0;
`endif

  assign hs_s     = sel_valid_r & out_ready;
  assign wr_ok_s  = wr_en & (state_r != ST_RUN);
  assign wr_bad_s = wr_en & (state_r == ST_RUN);

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_s     = state_r;
    s_s         = s_r;
    sel_valid_s = sel_valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    step_s      = step_r;
    pass_s      = pass_r;
    passes_s    = passes_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (passes != '0) begin
            state_s     = ST_RUN;
            passes_s    = passes;
            pass_s      = '0;
            step_s      = 2'd0;
            s_s         = start_off_s;
            sel_valid_s = 1'b1;
            busy_s      = 1'b1;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          // Pass boundaries are counted in handshakes so a rotated order wraps correctly.
          step_s = step_r + 2'd1;
          s_s    = s_r + 2'd1;
          if (step_r == 2'd3) begin
            if (pass_r == (passes_r - PASS_W'(1))) begin
              state_s     = ST_DONE;
              s_s         = s_r;
              sel_valid_s = 1'b0;
              busy_s      = 1'b0;
              done_s      = 1'b1;
              step_s      = 2'd0;
              pass_s      = '0;
            end else begin
              pass_s = pass_r + PASS_W'(1);
            end
          end else begin
            pass_s = pass_r;
          end
        end else begin
          s_s = s_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s     = ST_IDLE;
        sel_valid_s = 1'b0;
        busy_s      = 1'b0;
        step_s      = 2'd0;
        pass_s      = '0;
      end
    endcase
  end

  // FSM, select, handshake status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      s_r         <= 2'd0;
      sel_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      step_r      <= 2'd0;
      pass_r      <= '0;
      passes_r    <= '0;
    end else begin
      state_r     <= state_s;
      s_r         <= s_s;
      sel_valid_r <= sel_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      step_r      <= step_s;
      pass_r      <= pass_s;
      passes_r    <= passes_s;
    end
  end

  // Operand bank: writable only outside RUN so the mux sees stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        w_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      w_r[wr_addr] <= wr_data;
    end
  end

  // Sticky flag for writes attempted during RUN; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
    end else if (wr_bad_s) begin
      wr_err_r <= 1'b1;
    end
  end

  assign W0        = w_r[0];
  assign W1        = w_r[1];
  assign W2        = w_r[2];
  assign W3        = w_r[3];
  assign S         = s_r;
  assign sel_valid = sel_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign wr_err    = wr_err_r;

endmodule
